seg_scan_driver: RTL and testbench

- Parametrised multiplexed 7-segment display driver for DIGITS digits on a shared active-low segment bus.
- Time-slices the digit anodes, decodes 4-bit codes per digit in hex or decimal mode, and adds decimal points, per-digit blanking and leading-zero suppression.
- Double-buffers input data so updates land only on frame boundaries, with no tearing.
- Sits between the counter/clock datapath and the board's display pins.

---
 rtl/seg_pkg.sv | 28 ++
 rtl/seg_decode.sv | 42 ++++
 rtl/seg_scan_driver.sv | 213 +++++++++++++++++++++
 tb/tb_seg_scan_driver.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and segment patterns for the multiplexed 7-segment driver.
// Patterns are active low, ordered {g,f,e,d,c,b,a}; seg_t adds dp as bit 7.
package seg_pkg;

   typedef logic [7:0] seg_t;

   localparam logic [6:0] SEG_0    = 7'h40;
   localparam logic [6:0] SEG_1    = 7'h79;
   localparam logic [6:0] SEG_2    = 7'h24;
   localparam logic [6:0] SEG_3    = 7'h30;
   localparam logic [6:0] SEG_4    = 7'h19;
   localparam logic [6:0] SEG_5    = 7'h12;
   localparam logic [6:0] SEG_6    = 7'h02;
   localparam logic [6:0] SEG_7    = 7'h78;
   localparam logic [6:0] SEG_8    = 7'h00;
   localparam logic [6:0] SEG_9    = 7'h10;
   localparam logic [6:0] SEG_A    = 7'h08;
   localparam logic [6:0] SEG_B    = 7'h03;
   localparam logic [6:0] SEG_C    = 7'h46;
   localparam logic [6:0] SEG_D    = 7'h21;
   localparam logic [6:0] SEG_E    = 7'h06;
   localparam logic [6:0] SEG_F    = 7'h0E;
   localparam logic [6:0] SEG_DASH = 7'h3F;
   localparam logic [6:0] SEG_NONE = 7'h7F;

   localparam seg_t SEG_OFF = 8'hFF;

endpackage

// File: rtl/seg_decode.sv
// Combinational digit decoder: 4-bit code to active-low segments + dp.
// Ports: i_code, i_hex_mode, i_blank (segments dark), i_dp (1 = lit), o_seg.
module seg_decode
   import seg_pkg::*;
(
   input  logic [3:0] i_code,
   input  logic       i_hex_mode,
   input  logic       i_blank,
   input  logic       i_dp,
   output seg_t       o_seg
);

   logic [6:0] w_pat;

   always_comb begin
      w_pat = SEG_DASH;
      case (i_code)
         4'h0: w_pat = SEG_0;
         4'h1: w_pat = SEG_1;
         4'h2: w_pat = SEG_2;
         4'h3: w_pat = SEG_3;
         4'h4: w_pat = SEG_4;
         4'h5: w_pat = SEG_5;
         4'h6: w_pat = SEG_6;
         4'h7: w_pat = SEG_7;
         4'h8: w_pat = SEG_8;
         4'h9: w_pat = SEG_9;
         4'hA: w_pat = i_hex_mode ? SEG_A : SEG_DASH;
         4'hB: w_pat = i_hex_mode ? SEG_B : SEG_DASH;
         4'hC: w_pat = i_hex_mode ? SEG_C : SEG_DASH;
         4'hD: w_pat = i_hex_mode ? SEG_D : SEG_DASH;
         4'hE: w_pat = i_hex_mode ? SEG_E : SEG_DASH;
         4'hF: w_pat = i_hex_mode ? SEG_F : SEG_DASH;
         default: w_pat = SEG_DASH;
      endcase
   end

   // dp is independent of segment blanking; the caller clears it
   // when the whole digit must go dark.
   assign o_seg = {~i_dp, i_blank ? SEG_NONE : w_pat};

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed DIGITS-digit 7-segment scanner with frame-aligned double buffer.
// Ports: clk, rst, digits_in/dp_in/blank_in/hex_mode/lzs_en/load in;
//        seg_out (active low), an_out, frame_done out.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int DIGITS        = 4,
   parameter int CLK_DIV       = 50000,
   parameter int BLANK_CYC     = 16,
   parameter bit AN_ACTIVE_LOW = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*DIGITS-1:0]   digits_in,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic [DIGITS-1:0]     blank_in,
   input  logic                  hex_mode,
   input  logic                  lzs_en,
   input  logic                  load,
   output logic [7:0]            seg_out,
   output logic [DIGITS-1:0]     an_out,
   output logic                  frame_done
);

   localparam int PW = $clog2(CLK_DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0] GUARD     = PW'(BLANK_CYC);
   localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

   localparam logic [DIGITS-1:0] AN_OFF =
      AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

   logic [PW-1:0]         r_presc;
   logic [IW-1:0]         r_idx;

   logic [4*DIGITS-1:0]   r_sh_dig;
   logic [DIGITS-1:0]     r_sh_dp;
   logic [DIGITS-1:0]     r_sh_blk;
   logic                  r_sh_hex;
   logic                  r_sh_lzs;
   logic                  r_pending;

   logic [4*DIGITS-1:0]   r_ac_dig;
   logic [DIGITS-1:0]     r_ac_dp;
   logic [DIGITS-1:0]     r_ac_blk;
   logic                  r_ac_hex;
   logic                  r_ac_lzs;

   logic                  w_slot_end;
   logic                  w_wrap;
   logic [PW-1:0]         w_presc_nxt;
   logic [IW-1:0]         w_idx_nxt;

   logic [4*DIGITS-1:0]   w_ac_dig_nxt;
   logic [DIGITS-1:0]     w_ac_dp_nxt;
   logic [DIGITS-1:0]     w_ac_blk_nxt;
   logic                  w_ac_hex_nxt;
   logic                  w_ac_lzs_nxt;

   logic [DIGITS-1:0]     w_lzs_mask;
   logic                  w_all_zero;
   logic [3:0]            w_code;
   logic                  w_dp_sel;
   logic                  w_blk_sel;
   logic                  w_lzs_sel;
   logic [DIGITS-1:0]     w_an_hot;
   seg_t                  w_seg;

   // ---------------- prescaler and digit index ----------------
   assign w_slot_end = (r_presc == PRESC_MAX);
   assign w_wrap     = w_slot_end && (r_idx == IDX_MAX);

   always_comb begin
      w_presc_nxt = r_presc + 1'b1;
      w_idx_nxt   = r_idx;
      if (w_slot_end) begin
         w_presc_nxt = '0;
         if (r_idx == IDX_MAX) begin
            w_idx_nxt = '0;
         end else begin
            w_idx_nxt = r_idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_presc <= '0;
         r_idx   <= '0;
      end else begin
         r_presc <= w_presc_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   // ---------------- double buffer ----------------
   // A load coinciding with the wrap goes straight to active, so
   // pending is never left set for data that is already displayed.
   always_comb begin
      w_ac_dig_nxt = r_ac_dig;
      w_ac_dp_nxt  = r_ac_dp;
      w_ac_blk_nxt = r_ac_blk;
      w_ac_hex_nxt = r_ac_hex;
      w_ac_lzs_nxt = r_ac_lzs;
      if (w_wrap) begin
         if (load) begin
            w_ac_dig_nxt = digits_in;
            w_ac_dp_nxt  = dp_in;
            w_ac_blk_nxt = blank_in;
            w_ac_hex_nxt = hex_mode;
            w_ac_lzs_nxt = lzs_en;
         end else if (r_pending) begin
            w_ac_dig_nxt = r_sh_dig;
            w_ac_dp_nxt  = r_sh_dp;
            w_ac_blk_nxt = r_sh_blk;
            w_ac_hex_nxt = r_sh_hex;
            w_ac_lzs_nxt = r_sh_lzs;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sh_dig  <= '0;
         r_sh_dp   <= '0;
         r_sh_blk  <= '0;
         r_sh_hex  <= 1'b0;
         r_sh_lzs  <= 1'b0;
         r_pending <= 1'b0;
      end else begin
         if (load) begin
            r_sh_dig <= digits_in;
            r_sh_dp  <= dp_in;
            r_sh_blk <= blank_in;
            r_sh_hex <= hex_mode;
            r_sh_lzs <= lzs_en;
         end
         if (w_wrap) begin
            r_pending <= 1'b0;
         end else if (load) begin
            r_pending <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ac_dig <= '0;
         r_ac_dp  <= '0;
         r_ac_blk <= '0;
         r_ac_hex <= 1'b0;
         r_ac_lzs <= 1'b0;
      end else begin
         r_ac_dig <= w_ac_dig_nxt;
         r_ac_dp  <= w_ac_dp_nxt;
         r_ac_blk <= w_ac_blk_nxt;
         r_ac_hex <= w_ac_hex_nxt;
         r_ac_lzs <= w_ac_lzs_nxt;
      end
   end

   // ---------------- leading-zero mask ----------------
   // Walk from the most significant digit down; a digit is suppressed
   // while it and everything above it are zero. Digit 0 always shows.
   always_comb begin
      w_lzs_mask = '0;
      w_all_zero = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         w_all_zero    = w_all_zero && (w_ac_dig_nxt[4*i +: 4] == 4'h0);
         w_lzs_mask[i] = w_ac_lzs_nxt && w_all_zero;
      end
   end

   // ---------------- digit select and decode ----------------
   // The output registers are fed from next-state values so that the
   // registered outputs line up with presc/idx/active of the same cycle;
   // new frame data is therefore on seg_out with frame_done.
   assign w_code    = w_ac_dig_nxt[4*int'(w_idx_nxt) +: 4];
   assign w_dp_sel  = w_ac_dp_nxt[w_idx_nxt];
   assign w_blk_sel = w_ac_blk_nxt[w_idx_nxt];
   assign w_lzs_sel = w_lzs_mask[w_idx_nxt];

   seg_decode u_dec (
      .i_code     (w_code),
      .i_hex_mode (w_ac_hex_nxt),
      .i_blank    (w_blk_sel | w_lzs_sel),
      .i_dp       (w_dp_sel & ~w_blk_sel),
      .o_seg      (w_seg)
   );

   always_comb begin
      w_an_hot = '0;
      if (w_presc_nxt >= GUARD) begin
         w_an_hot[w_idx_nxt] = 1'b1;
      end
   end

   // ---------------- output registers ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_out    <= SEG_OFF;
         an_out     <= AN_OFF;
         frame_done <= 1'b0;
      end else begin
         seg_out    <= w_seg;
         an_out     <= AN_ACTIVE_LOW ? ~w_an_hot : w_an_hot;
         frame_done <= w_wrap;
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (DIGITS=4, CLK_DIV=4, BLANK_CYC=1).
// Reference model works per frame: each frame shows the last load made up to its start.
module tb_seg_scan_driver;

   localparam int D  = 4;
   localparam int CD = 4;
   localparam int BC = 1;
   localparam int FR = D * CD;

   typedef struct packed {
      logic [15:0] dig;
      logic [3:0]  dp;
      logic [3:0]  blk;
      logic        hex;
      logic        lzs;
   } img_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] digits_in;
   logic [3:0]  dp_in;
   logic [3:0]  blank_in;
   logic        hex_mode;
   logic        lzs_en;
   logic        load;
   logic [7:0]  seg_out;
   logic [3:0]  an_out;
   logic        frame_done;

   int   total = 0;
   int   bad   = 0;
   int   n     = 0;
   img_t last_ld;
   img_t frame;

   always #5 clk = ~clk;

   seg_scan_driver #(
      .DIGITS        (D),
      .CLK_DIV       (CD),
      .BLANK_CYC     (BC),
      .AN_ACTIVE_LOW (1'b1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .digits_in  (digits_in),
      .dp_in      (dp_in),
      .blank_in   (blank_in),
      .hex_mode   (hex_mode),
      .lzs_en     (lzs_en),
      .load       (load),
      .seg_out    (seg_out),
      .an_out     (an_out),
      .frame_done (frame_done)
   );

   function automatic string lit_of(logic [3:0] c, logic hx);
      if (c > 4'd9 && !hx) return "g";
      case (c)
         4'h0: return "abcdef";
         4'h1: return "bc";
         4'h2: return "abdeg";
         4'h3: return "abcdg";
         4'h4: return "bcfg";
         4'h5: return "acdfg";
         4'h6: return "acdefg";
         4'h7: return "abc";
         4'h8: return "abcdefg";
         4'h9: return "abcdfg";
         4'hA: return "abcefg";
         4'hB: return "cdefg";
         4'hC: return "adef";
         4'hD: return "bcdeg";
         4'hE: return "adefg";
         default: return "aefg";
      endcase
   endfunction

   function automatic logic [6:0] lit_mask(logic [3:0] c, logic hx);
      string      s;
      logic [6:0] m;
      s = lit_of(c, hx);
      m = '0;
      for (int k = 0; k < s.len(); k++) m[int'(s[k]) - 97] = 1'b1;
      return m;
   endfunction

   function automatic logic [7:0] exp_seg(img_t f, int i);
      logic z;
      if (f.blk[i]) return 8'hFF;
      z = f.lzs && (i >= 1);
      for (int j = i; j < D; j++) if (f.dig[4*j +: 4] != 4'h0) z = 1'b0;
      return {~f.dp[i], z ? 7'h7F : ~lit_mask(f.dig[4*i +: 4], f.hex)};
   endfunction

   function automatic img_t mk(logic [15:0] dg, logic [3:0] dp, logic [3:0] bk,
                               logic hx, logic lz);
      img_t v;
      v.dig = dg; v.dp = dp; v.blk = bk; v.hex = hx; v.lzs = lz;
      return v;
   endfunction

   function automatic img_t rnd_img();
      return mk(16'($urandom), 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0),
                1'($urandom), 1'($urandom));
   endfunction

   task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s n=%0d got=%h want=%h", tag, n, obs, exp);
      end
   endtask

   task automatic cyc(input logic ld, input img_t v);
      img_t g;
      int   idx;
      g = ld ? v : rnd_img();
      digits_in = g.dig; dp_in = g.dp; blank_in = g.blk;
      hex_mode  = g.hex; lzs_en = g.lzs; load = ld;
      @(posedge clk);
      n++;
      if (ld) last_ld = v;
      if (n % FR == 0) frame = last_ld;
      #1;
      load = 1'b0;
      idx = (n / CD) % D;
      check("frame_done", {7'd0, frame_done}, {7'd0, (n % FR == 0)});
      check("an_out", {4'd0, an_out},
            {4'd0, (n % CD >= BC) ? ~(4'b1 << idx) : 4'hF});
      check("seg_out", seg_out, exp_seg(frame, idx));
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) cyc(1'b0, last_ld);
   endtask

   task automatic to_wrap();
      for (int i = 0; i < FR && ((n + 1) % FR != 0); i++) cyc(1'b0, last_ld);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_seg", seg_out, 8'hFF);
      check("rst_an", {4'd0, an_out}, 8'h0F);
      check("rst_fd", {7'd0, frame_done}, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      last_ld = '0;
      frame = '0;
   endtask

   initial begin
      rst = 1'b1; load = 1'b0;
      digits_in = '0; dp_in = '0; blank_in = '0; hex_mode = 1'b0; lzs_en = 1'b0;
      last_ld = '0; frame = '0;
      repeat (2) @(negedge clk);
      do_reset();
      idle(2);

      cyc(1'b1, mk(16'h1234, 4'h0, 4'h0, 1'b0, 1'b0));
      idle(2 * FR);

      cyc(1'b1, mk(16'hABCD, 4'h0, 4'h0, 1'b1, 1'b0));
      idle(2 * FR);
      cyc(1'b1, mk(16'hABCD, 4'h0, 4'h0, 1'b0, 1'b0));
      idle(2 * FR);

      cyc(1'b1, mk(16'h0070, 4'b1000, 4'h0, 1'b0, 1'b1));
      idle(2 * FR);

      to_wrap();
      cyc(1'b0, last_ld);
      cyc(1'b1, mk(16'h1111, 4'h0, 4'h0, 1'b0, 1'b0));
      idle(5);
      cyc(1'b1, mk(16'h2222, 4'h0, 4'h0, 1'b0, 1'b0));
      idle(2 * FR);

      to_wrap();
      cyc(1'b1, mk(16'h5555, 4'h0, 4'h0, 1'b0, 1'b0));
      check("wrap_fd", {7'd0, frame_done}, 8'h01);
      check("wrap_seg", seg_out, 8'h92);
      idle(FR);

      cyc(1'b1, mk(16'h9999, 4'hF, 4'h0, 1'b0, 1'b0));
      idle(3);
      do_reset();
      idle(2 * FR);

      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 9) == 0) cyc(1'b1, rnd_img());
         else cyc(1'b0, last_ld);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
